conv_result_drain: RTL and testbench

Drains the per-channel result BRAMs written by the conv_2d engine and serialises them onto one valid/ready output stream. It reads all RESULT_D banks in parallel at a shared address. It then emits RESULT_D beats, channel 0 first, before advancing the address. It sits between the conv engine's result RAMs and the downstream writeback/DMA path, and runs after the conv engine finishes.

---
 rtl/conv_result_drain.sv | 184 ++++++++++++++++++
 tb/tb_conv_result_drain.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/conv_result_drain.sv
// Serialises the per-channel conv result banks onto one valid/ready stream.
// All banks are read in parallel at one address; the channels are then sent in order, 0 first.
module conv_result_drain #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RES_WIDTH  = DATA_WIDTH * 4,
  parameter int unsigned IMG_W      = 8,
  parameter int unsigned IMG_H      = 8,
  parameter int unsigned FILTER_W   = 3,
  parameter int unsigned FILTER_H   = 3,
  parameter int unsigned STRIDE_W   = 1,
  parameter int unsigned STRIDE_H   = 1,
  parameter int unsigned RESULT_D   = 8,
  localparam int unsigned RESULT_W  = (IMG_W - FILTER_W) / STRIDE_W + 1,
  localparam int unsigned RESULT_H  = (IMG_H - FILTER_H) / STRIDE_H + 1,
  localparam int unsigned RESULT_N  = RESULT_W * RESULT_H,
  localparam int unsigned RESULT_RAM_ADDR_WIDTH = (RESULT_N > 1) ? $clog2(RESULT_N) : 1,
  localparam int unsigned RESULT_D_ADDR_WIDTH   = (RESULT_D > 1) ? $clog2(RESULT_D) : 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      done,
  output logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0] result_rdaddress,
  input  logic [RES_WIDTH*RESULT_D-1:0]             result_data_in,
  output logic [RES_WIDTH-1:0]                      out_data,
  output logic [RESULT_D_ADDR_WIDTH-1:0]            out_chan,
  output logic [RESULT_RAM_ADDR_WIDTH-1:0]          out_addr,
  output logic                                      out_last,
  output logic                                      out_val,
  input  logic                                      out_rdy
);

  localparam int unsigned PtrW = RESULT_RAM_ADDR_WIDTH + 1;
  localparam logic [PtrW-1:0] NumWords = PtrW'(RESULT_N);
  localparam logic [RESULT_RAM_ADDR_WIDTH-1:0] LastAddr = RESULT_RAM_ADDR_WIDTH'(RESULT_N - 1);
  localparam logic [RESULT_D_ADDR_WIDTH-1:0] LastChan = RESULT_D_ADDR_WIDTH'(RESULT_D - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  typedef logic [RESULT_D-1:0][RES_WIDTH-1:0] vec_t;

  state_e                             st_q, st_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  logic [PtrW-1:0]                    rd_ptr_q, rd_ptr_d;
  logic [RESULT_RAM_ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                               rd_inflight_q, rd_inflight_d;
  logic                               rd_ret_q, rd_ret_d;
  vec_t                               h_q, h_d;
  vec_t                               p_q, p_d;
  logic                               h_full_q, h_full_d;
  logic                               p_full_q, p_full_d;
  logic [RESULT_RAM_ADDR_WIDTH-1:0]   h_addr_q, h_addr_d;
  logic [RESULT_RAM_ADDR_WIDTH-1:0]   p_addr_q, p_addr_d;
  logic [RESULT_D_ADDR_WIDTH-1:0]     chan_q, chan_d;

  vec_t rd_data;
  logic hs, vacate, last_hs, issue;

  assign rd_data = result_data_in;
  assign hs      = h_full_q && out_rdy;
  assign vacate  = hs && (chan_q == LastChan);
  assign last_hs = vacate && (h_addr_q == LastAddr);
  // One read in flight at most, so a free slot seen at issue is still free on return.
  assign issue   = (st_q == StRun) && !rd_inflight_q && !rd_ret_q && (rd_ptr_q < NumWords) &&
                   (!p_full_q || !h_full_q);

  always_comb begin
    st_d          = st_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    rd_ptr_d      = rd_ptr_q;
    rd_addr_d     = rd_addr_q;
    rd_inflight_d = issue;
    rd_ret_d      = rd_inflight_q;
    h_d           = h_q;
    p_d           = p_q;
    h_full_d      = h_full_q;
    p_full_d      = p_full_q;
    h_addr_d      = h_addr_q;
    p_addr_d      = p_addr_q;
    chan_d        = chan_q;

    if (issue) begin
      rd_addr_d = rd_ptr_q[RESULT_RAM_ADDR_WIDTH-1:0];
      rd_ptr_d  = rd_ptr_q + PtrW'(1);
    end

    // H is a shift register so out_data always comes straight from word 0.
    if (hs) begin
      if (vacate) begin
        chan_d = '0;
        if (p_full_q) begin
          h_d      = p_q;
          h_addr_d = p_addr_q;
          p_full_d = 1'b0;
        end else begin
          h_full_d = 1'b0;
        end
      end else begin
        chan_d = chan_q + RESULT_D_ADDR_WIDTH'(1);
        for (int k = 0; k < int'(RESULT_D) - 1; k++) begin
          h_d[k] = h_q[k+1];
        end
      end
    end

    if (rd_ret_q) begin
      if (!h_full_d) begin
        h_d      = rd_data;
        h_addr_d = rd_addr_q;
        h_full_d = 1'b1;
      end else begin
        p_d      = rd_data;
        p_addr_d = rd_addr_q;
        p_full_d = 1'b1;
      end
    end

    unique case (st_q)
      StIdle: begin
        if (start) begin
          st_d     = StRun;
          busy_d   = 1'b1;
          rd_ptr_d = '0;
          chan_d   = '0;
        end
      end
      StRun: begin
        if (last_hs) begin
          st_d   = StDone;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      StDone: st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q          <= StIdle;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_ptr_q      <= '0;
      rd_addr_q     <= '0;
      rd_inflight_q <= 1'b0;
      rd_ret_q      <= 1'b0;
      h_q           <= '0;
      p_q           <= '0;
      h_full_q      <= 1'b0;
      p_full_q      <= 1'b0;
      h_addr_q      <= '0;
      p_addr_q      <= '0;
      chan_q        <= '0;
    end else begin
      st_q          <= st_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_addr_q     <= rd_addr_d;
      rd_inflight_q <= rd_inflight_d;
      rd_ret_q      <= rd_ret_d;
      h_q           <= h_d;
      p_q           <= p_d;
      h_full_q      <= h_full_d;
      p_full_q      <= p_full_d;
      h_addr_q      <= h_addr_d;
      p_addr_q      <= p_addr_d;
      chan_q        <= chan_d;
    end
  end

  assign result_rdaddress = {RESULT_D{rd_addr_q}};
  assign busy             = busy_q;
  assign done             = done_q;
  assign out_val          = h_full_q;
  assign out_data         = h_q[0];
  assign out_chan         = chan_q;
  assign out_addr         = h_addr_q;
  assign out_last         = h_full_q && (chan_q == LastChan) && (h_addr_q == LastAddr);

endmodule

// File: tb/tb_conv_result_drain.sv
// Directed bench for conv_result_drain: default 6x6x8 instance plus a stride-2 (3x3x8) instance.
module tb_conv_result_drain;

  logic clk = 1'b0;
  logic rst_n;
  logic start_v;
  logic sel;
  logic out_rdy;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // Default instance: 36 words per bank, 8 banks.
  logic             start0, busy0, done0, val0, last0;
  logic [7:0][5:0]  rdaddr0;
  logic [7:0][31:0] rdata0;
  logic [31:0]      data0;
  logic [2:0]       chan0;
  logic [5:0]       addr0;

  // Stride-2 instance: 9 words per bank, 8 banks.
  logic             start1, busy1, done1, val1, last1;
  logic [7:0][3:0]  rdaddr1;
  logic [7:0][31:0] rdata1;
  logic [31:0]      data1;
  logic [2:0]       chan1;
  logic [3:0]       addr1;
  logic [3:0]       max1 = '0;

  assign start0 = start_v & ~sel;
  assign start1 = start_v & sel;

  conv_result_drain u_dut0 (
    .clk(clk), .reset(rst_n), .start(start0), .busy(busy0), .done(done0),
    .result_rdaddress(rdaddr0), .result_data_in(rdata0), .out_data(data0), .out_chan(chan0),
    .out_addr(addr0), .out_last(last0), .out_val(val0), .out_rdy(out_rdy)
  );

  conv_result_drain #(.STRIDE_W(2), .STRIDE_H(2)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(start1), .busy(busy1), .done(done1),
    .result_rdaddress(rdaddr1), .result_data_in(rdata1), .out_data(data1), .out_chan(chan1),
    .out_addr(addr1), .out_last(last1), .out_val(val1), .out_rdy(out_rdy)
  );

  // Synchronous-read bank models: word = chan*256 + addr, each bank using its own address slice.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      rdata0[k] <= 32'(k * 256) + 32'(rdaddr0[k]);
      rdata1[k] <= 32'(k * 256) + 32'(rdaddr1[k]);
    end
    if (rdaddr1[0] > max1) max1 <= rdaddr1[0];
  end

  logic        m_val, m_last, m_busy, m_done;
  logic [31:0] m_data;
  logic [2:0]  m_chan;
  logic [5:0]  m_addr;
  assign m_val  = sel ? val1  : val0;
  assign m_last = sel ? last1 : last0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_data = sel ? data1 : data0;
  assign m_chan = sel ? chan1 : chan0;
  assign m_addr = sel ? {2'b00, addr1} : addr0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called just before a negedge-aligned start pulse; returns at the first negedge after acceptance.
  task automatic kick();
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    chk("busy_after_start", m_busy, 1);
    chk("val_low_after_start", m_val, 0);
  endtask

  // mode 0: out_rdy high; 1: random out_rdy; 2: out_rdy high but held low 10 cycles on out_last.
  task automatic drain(input int nb, input int mode, input int abort_at, input bit poke);
    int beat = 0, dones = 0, first_val = -1, last_hs = -1, hold = 0;
    bit stall = 1'b0;
    logic [42:0] prev = '0, snap;
    logic [41:0] expb;
    int ech, ead;
    for (int cyc = 0; cyc < nb * 4 + 50; cyc++) begin
      snap = {m_val, m_last, m_chan, m_addr, m_data};
      if (first_val < 0 && m_val) begin
        first_val = cyc;
        chk("first_val_latency", cyc, 3);
      end
      if (stall) chk("stall_stable", snap, prev);
      if (m_done) begin
        dones++;
        chk("done_after_last", cyc, last_hs + 1);
        chk("busy_low_at_done", m_busy, 0);
      end else if (dones > 0) begin
        break;
      end
      if (poke) start_v = m_busy || m_done;
      if (mode == 1) out_rdy = ($urandom_range(1) != 0);
      else if (mode == 2 && m_val && m_last && hold < 10) begin
        out_rdy = 1'b0;
        hold++;
      end else out_rdy = 1'b1;
      if (m_val && out_rdy) begin
        ech  = beat % 8;
        ead  = beat / 8;
        expb = {beat == nb - 1, 3'(ech), 6'(ead), 32'(ech * 256 + ead)};
        chk("beat", {m_last, m_chan, m_addr, m_data}, expb);
        beat++;
        last_hs = cyc;
        if (beat == abort_at) return;
      end
      stall = m_val && !out_rdy;
      prev  = snap;
      @(negedge clk);
    end
    start_v = 1'b0;
    chk("beats_total", beat, nb);
    chk("done_count", dones, 1);
    if (mode == 2) chk("last_hold_cycles", hold, 10);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_v = 1'b0;
    sel     = 1'b0;
    out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl0", {busy0, done0, val0, last0, chan0, addr0}, 0);
    chk("reset_data0", data0, 0);
    chk("reset_rdaddr0", rdaddr0, 0);
    chk("reset_ctrl1", {busy1, done1, val1, last1, chan1, addr1, rdaddr1}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full drain, no backpressure.
    kick();
    drain(288, 0, 0, 1'b0);

    // Random backpressure.
    kick();
    drain(288, 1, 0, 1'b0);

    // start held while busy and during the done cycle is ignored.
    kick();
    drain(288, 0, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("no_restart_after_done", {busy0, val0}, 0);

    // A fresh start after done repeats the whole drain.
    kick();
    drain(288, 0, 0, 1'b0);

    // Backpressure held on the final beat.
    kick();
    drain(288, 2, 0, 1'b0);

    // Reset in the middle of a drain.
    kick();
    drain(288, 0, 100, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_val_low", val0, 0);
    chk("abort_busy_low", busy0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done0, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_after_release", {busy0, done0, val0}, 0);
    kick();
    drain(288, 0, 0, 1'b0);

    // Stride-2 instance: 3x3 words, 72 beats.
    sel = 1'b1;
    @(negedge clk);
    kick();
    drain(72, 0, 0, 1'b0);
    chk("stride2_max_rdaddr", max1, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
